// File: rtl/data_rx_deser.sv
// data_rx_deser: serial-to-parallel receiver with a first-word fall-through word FIFO.
// serial_in is sampled on each cnt_up strobe. Every DATA_W bits, the assembled word
// is pushed into a FIFO_DEPTH-entry buffer, and rd_en drains that buffer.
// Optional feature: define RX_CRC16_EN to include the USB CRC16 residual checker.
// When the macro is undefined, crc_ok is tied to 0.
module data_rx_deser #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int LSB_FIRST  = 1
) (
    input  logic                              clk,
    input  logic                              n_rst,
    input  logic                              clear,
    input  logic                              serial_in,
    input  logic                              cnt_up,
    input  logic                              rd_en,
    output logic [DATA_W-1:0]                 parallel_out,
    output logic                              byte_rcv,
    output logic                              empty,
    output logic                              full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              overrun,
    output logic                              crc_ok
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CW    = $clog2(FIFO_DEPTH+1);

    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_next;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CW-1:0]     count_next;
    logic              word_done;
    logic              push;
    logic              pop;
    logic              drop;

    // Next shifter value: the incoming bit enters at the MSB end or at the LSB end
    generate
        if (LSB_FIRST != 0) begin : g_lsb
            assign shreg_next = {serial_in, shreg[DATA_W-1:1]};
        end else begin : g_msb
            assign shreg_next = {shreg[DATA_W-2:0], serial_in};
        end
    endgenerate

    // A word completes on the strobe that carries its last bit. While the FIFO is full,
    // that word is stored only if a pop on the same edge frees a slot.
    always_comb begin
        word_done = cnt_up && (bit_cnt == CNT_W'(DATA_W-1));
        pop       = rd_en && !empty;
        push      = word_done && (!full || pop);
        drop      = word_done && full && !pop;
        count_next = fifo_count;
        if (push && !pop)
            count_next = fifo_count + CW'(1);
        else if (pop && !push)
            count_next = fifo_count - CW'(1);
    end

    // Bit counter and shifter; clear discards any partial word
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (clear) begin
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (cnt_up) begin
            shreg   <= shreg_next;
            bit_cnt <= word_done ? '0 : bit_cnt + CNT_W'(1);
        end
    end

    // FIFO storage; this block has no reset because the valid range is tracked by the pointers
    always_ff @(posedge clk) begin
        if (push && !clear)
            mem[wr_ptr] <= shreg_next;
    end

    // FIFO pointers, count, and status flags, all registered
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            empty      <= 1'b1;
            full       <= 1'b0;
            byte_rcv   <= 1'b0;
            overrun    <= 1'b0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            empty      <= 1'b1;
            full       <= 1'b0;
            byte_rcv   <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_count <= count_next;
            empty      <= (count_next == '0);
            full       <= (count_next == CW'(FIFO_DEPTH));
            byte_rcv   <= push;
            overrun    <= overrun | drop;
        end
    end

    // First-word fall-through: the head of registered storage is presented directly on the output
    assign parallel_out = empty ? '0 : mem[rd_ptr];

`ifdef RX_CRC16_EN
    logic [15:0] crc;
    logic        crc_fb;

    assign crc_fb = crc[15] ^ serial_in;

    // Serial USB CRC16 (x^16+x^15+x^2+1), updated with every received bit
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            crc <= 16'hFFFF;
        else if (clear)
            crc <= 16'hFFFF;
        else if (cnt_up)
            crc <= {crc[14:0], 1'b0} ^ (crc_fb ? 16'h8005 : 16'h0000);
    end

    assign crc_ok = (crc == 16'h800D);
`else
    assign crc_ok = 1'b0;
`endif

endmodule

// File: tb/tb_data_rx_deser.sv
// Scoreboard bench for data_rx_deser. Two instances share the same stimulus:
// one receives LSB first and the other receives MSB first.
// A monitor compares every FIFO pop against the expected-word queues.
module tb_data_rx_deser;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       clear;
    logic       serial_in;
    logic       cnt_up;
    logic       rd_en;
    logic [7:0] parallel_out, parallel_out_m;
    logic       byte_rcv, byte_rcv_m;
    logic       empty, empty_m;
    logic       full, full_m;
    logic [2:0] fifo_count, fifo_count_m;
    logic       overrun, overrun_m;
    logic       crc_ok, crc_ok_m;

    int n_vec = 0;
    int n_err = 0;
    int rcv_cnt = 0;
    int rcv_base;
    logic [7:0] exp_q[$];
    logic [7:0] exp_m_q[$];

    always #5 clk = ~clk;

    data_rx_deser #(.DATA_W(8), .FIFO_DEPTH(4), .LSB_FIRST(1)) u_dut (
        .clk(clk), .n_rst(n_rst), .clear(clear), .serial_in(serial_in),
        .cnt_up(cnt_up), .rd_en(rd_en), .parallel_out(parallel_out),
        .byte_rcv(byte_rcv), .empty(empty), .full(full),
        .fifo_count(fifo_count), .overrun(overrun), .crc_ok(crc_ok)
    );

    data_rx_deser #(.DATA_W(8), .FIFO_DEPTH(4), .LSB_FIRST(0)) u_msb (
        .clk(clk), .n_rst(n_rst), .clear(clear), .serial_in(serial_in),
        .cnt_up(cnt_up), .rd_en(rd_en), .parallel_out(parallel_out_m),
        .byte_rcv(byte_rcv_m), .empty(empty_m), .full(full_m),
        .fifo_count(fifo_count_m), .overrun(overrun_m), .crc_ok(crc_ok_m)
    );

    // Monitor: every accepted pop must present the oldest expected word
    always @(negedge clk) begin
        if (n_rst === 1'b1 && clear === 1'b0 && rd_en === 1'b1 && empty === 1'b0) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL pop_lsb: got %h, required no word (queue empty)", parallel_out);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (parallel_out !== e) begin
                    n_err++;
                    $display("FAIL pop_lsb: got %h, required %h", parallel_out, e);
                end
            end
        end
        if (n_rst === 1'b1 && clear === 1'b0 && rd_en === 1'b1 && empty_m === 1'b0) begin
            n_vec++;
            if (exp_m_q.size() == 0) begin
                n_err++;
                $display("FAIL pop_msb: got %h, required no word (queue empty)", parallel_out_m);
            end else begin
                logic [7:0] e;
                e = exp_m_q.pop_front();
                if (parallel_out_m !== e) begin
                    n_err++;
                    $display("FAIL pop_msb: got %h, required %h", parallel_out_m, e);
                end
            end
        end
        if (byte_rcv === 1'b1)
            rcv_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int gap);
        serial_in = b;
        cnt_up = 1'b1;
        tick();
        cnt_up = 1'b0;
        repeat (gap) tick();
    endtask

    // Sends w LSB first. When pop_last is set, rd_en is asserted on the edge that completes the word.
    task automatic send_word(input logic [7:0] w, input int gap, input bit pop_last);
        for (int unsigned i = 0; i < 8; i++) begin
            if (i == 7 && pop_last)
                rd_en = 1'b1;
            send_bit(w[i], (i == 7) ? 0 : gap);
            rd_en = 1'b0;
        end
    endtask

    task automatic pop_n(input int n);
        rd_en = 1'b1;
        repeat (n) tick();
        rd_en = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_po"},  parallel_out, 0);
        chk({tag, "_br"},  byte_rcv, 0);
        chk({tag, "_emp"}, empty, 1);
        chk({tag, "_ful"}, full, 0);
        chk({tag, "_cnt"}, fifo_count, 0);
        chk({tag, "_ovr"}, overrun, 0);
        chk({tag, "_crc"}, crc_ok, 0);
        chk({tag, "_po_m"}, parallel_out_m, 0);
        chk({tag, "_emp_m"}, empty_m, 1);
    endtask

`ifdef RX_CRC16_EN
    // Byte-wise reflected CRC16: init FFFF, polynomial A001 (bit-reversed 8005), result inverted
    function automatic logic [15:0] usb_crc16(input logic [31:0] bytes);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int unsigned k = 0; k < 4; k++) begin
            c = c ^ {8'h00, bytes[8*k +: 8]};
            for (int unsigned j = 0; j < 8; j++)
                c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return ~c;
    endfunction
`endif

    initial begin
        n_rst = 1'b0; clear = 1'b0; serial_in = 1'b0; cnt_up = 1'b0; rd_en = 1'b0;
        repeat (3) tick();
        chk_reset_state("reset");
        n_rst = 1'b1;
        tick();

        // First word: bits 1,0,1,1,0,0,1,0 arrive back to back
        exp_q.push_back(8'h4D); exp_m_q.push_back(8'hB2);
        rcv_base = rcv_cnt;
        send_word(8'h4D, 0, 1'b0);
        chk("w1_br", byte_rcv, 1);
        chk("w1_po", parallel_out, 8'h4D);
        chk("w1_po_m", parallel_out_m, 8'hB2);
        chk("w1_cnt", fifo_count, 1);
        tick();
        chk("w1_br_pulse", byte_rcv, 0);
        chk("w1_rcv_n", rcv_cnt - rcv_base, 1);
        pop_n(1);
        chk("w1_emp", empty, 1);
        chk("w1_po0", parallel_out, 0);

        // Same word with a strobe only every 4th cycle
        exp_q.push_back(8'h4D); exp_m_q.push_back(8'hB2);
        rcv_base = rcv_cnt;
        send_word(8'h4D, 3, 1'b0);
        chk("gap_po_m", parallel_out_m, 8'hB2);
        tick(); tick();
        chk("gap_rcv_n", rcv_cnt - rcv_base, 1);
        pop_n(1);

        // Fill to full, then overrun on the 5th word
        exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33); exp_q.push_back(8'h44);
        exp_m_q.push_back(8'h88); exp_m_q.push_back(8'h44); exp_m_q.push_back(8'hCC); exp_m_q.push_back(8'h22);
        send_word(8'h11, 0, 1'b0);
        send_word(8'h22, 0, 1'b0);
        send_word(8'h33, 0, 1'b0);
        chk("fill3_full", full, 0);
        send_word(8'h44, 0, 1'b0);
        chk("fill4_full", full, 1);
        chk("fill4_cnt", fifo_count, 4);
        send_word(8'h55, 0, 1'b0);
        chk("ovr_br", byte_rcv, 0);
        chk("ovr_flag", overrun, 1);
        chk("ovr_cnt", fifo_count, 4);
        chk("ovr_head", parallel_out, 8'h11);
        pop_n(4);
        chk("drain_emp", empty, 1);
        chk("drain_po", parallel_out, 0);
        chk("ovr_sticky", overrun, 1);
        do_clear();
        chk("clr_ovr", overrun, 0);

        // Full FIFO with a pop on the edge that completes the 5th word
        exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33); exp_q.push_back(8'h44);
        exp_q.push_back(8'h55);
        exp_m_q.push_back(8'h88); exp_m_q.push_back(8'h44); exp_m_q.push_back(8'hCC); exp_m_q.push_back(8'h22);
        exp_m_q.push_back(8'hAA);
        send_word(8'h11, 0, 1'b0);
        send_word(8'h22, 0, 1'b0);
        send_word(8'h33, 0, 1'b0);
        send_word(8'h44, 0, 1'b0);
        send_word(8'h55, 0, 1'b1);
        chk("pp_cnt", fifo_count, 4);
        chk("pp_ovr", overrun, 0);
        chk("pp_br", byte_rcv, 1);
        chk("pp_head", parallel_out, 8'h22);
        chk("pp_full", full, 1);
        pop_n(4);
        chk("pp_emp", empty, 1);

        // A partial word followed by clear is discarded
        send_bit(1'b1, 0); send_bit(1'b1, 0); send_bit(1'b1, 0);
        do_clear();
        exp_q.push_back(8'hA5); exp_m_q.push_back(8'hA5);
        send_word(8'hA5, 0, 1'b0);
        chk("clrw_po", parallel_out, 8'hA5);
        chk("clrw_cnt", fifo_count, 1);
        chk("clrw_ovr", overrun, 0);
        pop_n(1);

        // Asynchronous reset in the middle of a word
        send_word(8'h3C, 0, 1'b0);
        send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0);
        #2 n_rst = 1'b0;
        #1;
        chk_reset_state("async");
        n_rst = 1'b1;
        tick();
        exp_q.push_back(8'h0F); exp_m_q.push_back(8'hF0);
        send_word(8'h0F, 0, 1'b0);
        chk("post_rst_po", parallel_out, 8'h0F);
        chk("post_rst_po_m", parallel_out_m, 8'hF0);
        pop_n(1);

`ifdef RX_CRC16_EN
        begin
            logic [15:0] c;
            logic [31:0] payload;
            payload = 32'h03020100;
            c = usb_crc16(payload);
            do_clear();
            for (int unsigned k = 0; k < 4; k++)
                send_word(payload[8*k +: 8], 0, 1'b0);
            send_word(c[7:0], 0, 1'b0);
            send_word(c[15:8], 0, 1'b0);
            chk("crc_good", crc_ok, 1);
            chk("crc_good_m", crc_ok_m, 1);
            do_clear();
            chk("crc_clr", crc_ok, 0);
            payload = 32'h03020101;
            for (int unsigned k = 0; k < 4; k++)
                send_word(payload[8*k +: 8], 0, 1'b0);
            send_word(c[7:0], 0, 1'b0);
            send_word(c[15:8], 0, 1'b0);
            chk("crc_bad", crc_ok, 0);
            do_clear();
        end
`else
        chk("crc_off", crc_ok, 0);
`endif

        tick();
        chk("q_lsb_left", exp_q.size(), 0);
        chk("q_msb_left", exp_m_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
